fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pc_in  input  32  current PC, driven by the program counter register.
REQ-004 SHALL have port: pc_wen  output  1  advance request to the program counter, pulses for the cycle an instruction is accepted.
REQ-005 SHALL have port: imemREN  output  1  instruction memory read enable.
REQ-006 SHALL have port: imemaddr  output  32  instruction memory address, equal to pc_in.
REQ-007 SHALL have port: ihit  input  1  instruction memory data valid this cycle (valid only while imemREN=1).
REQ-008 SHALL have port: imemload  input  32  instruction word returned by memory.
REQ-009 SHALL have port: flush  input  1  branch/jump redirect from a later stage; discards fetched work.
REQ-010 SHALL have port: stall  input  1  decode not ready; output register must hold.
REQ-011 SHALL have port: halt  input  1  halt seen downstream; stops fetching permanently until reset.
REQ-012 SHALL have ports: instr_out  output  32; npc_out  output  32 (pc+4); valid_out  output  1  IF/ID payload.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, HALTED; IDLE->FETCH unconditionally after one cycle.
REQ-014 In FETCH, SHALL assert imemREN when the output slot can accept (valid_out=0 or stall=0) and flush=0; imemaddr=pc_in always.
REQ-015 Accept = FETCH & imemREN & ihit; on accept SHALL register instr_out=imemload, npc_out=pc_in+4 (mod 2^32), valid_out=1 at next edge.
REQ-016 SHALL drive pc_wen combinationally equal to accept; pc_wen=0 in IDLE, HALTED, and any flush cycle.
REQ-017 When valid_out=1 and stall=1 and no flush, SHALL hold instr_out/npc_out/valid_out unchanged.
REQ-018 When valid_out=1, stall=0 and no accept, SHALL clear valid_out at next edge.
REQ-019 On flush=1, SHALL ignore ihit that cycle, clear valid_out at next edge, and insert one bubble cycle (imemREN=0) after flush so redirected pc_in settles.
REQ-020 flush SHALL take priority over stall and accept; halt SHALL take priority over flush.
REQ-021 On halt=1, SHALL enter HALTED at next edge; in HALTED imemREN=0, pc_wen=0, valid_out=0; exit only via reset.
REQ-022 pc+4 at 0xFFFFFFFC SHALL wrap to 0x00000000.

Reset
REQ-023 On nRST=0, SHALL asynchronously set state=IDLE, instr_out=0, npc_out=0, valid_out=0, skid contents cleared; imemREN=0 and pc_wen=0 while in reset.
REQ-024 Reset asserted mid-request SHALL discard any pending ihit; first fetch after release occurs two cycles later (IDLE then FETCH).

Configuration
REQ-025 Macro FETCH_SKID_EN SHALL, when defined, add a one-entry skid buffer: imemREN asserted in FETCH whenever the skid is empty (regardless of stall); an accept while output is held stalled fills the skid; skid drains to output on the first cycle stall=0; flush and halt clear the skid.
REQ-026 Without FETCH_SKID_EN, no skid storage SHALL exist and REQ-014 gating applies exactly.

Verification
REQ-027 Reset release, pc_in=0x0, ihit=1 every cycle, imemload=0x8C010004 -> cycle 2 imemREN=1, pc_wen=1; next edge instr_out=0x8C010004, npc_out=0x4, valid_out=1.
REQ-028 valid_out=1, stall=1 for 3 cycles -> outputs unchanged, pc_wen=0 (no macro) or one accept into skid then imemREN=0 (FETCH_SKID_EN).
REQ-029 flush=1 with ihit=1 -> pc_wen=0, valid_out=0 next edge, imemREN=0 the following cycle, fetch resumes at new pc_in.
REQ-030 halt=1 with flush=1 same cycle -> HALTED, imemREN=0, valid_out=0, stays until nRST pulse.
REQ-031 pc_in=0xFFFFFFFC accepted -> npc_out=0x00000000.
REQ-032 ihit=0 for 4 cycles in FETCH -> imemREN held 1, pc_wen=0, valid_out falls after stall=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with IDLE/FETCH/HALTED control and a one-cycle post-flush bubble.
// Define FETCH_SKID_EN to add a one-entry skid buffer behind the IF/ID register.
module fetch_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_in,
    output logic        pc_wen,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        flush,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out
);
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
    state_t state;
    logic bubble, accept, out_free;
    assign out_free = !valid_out || !stall;
    assign imemaddr = pc_in;
`ifdef FETCH_SKID_EN
    logic        skid_valid;
    logic [31:0] skid_instr, skid_npc;
    assign imemREN = state == FETCH && !bubble && !flush && !skid_valid;
`else
    assign imemREN = state == FETCH && !bubble && !flush && out_free;
`endif
    assign accept = imemREN && ihit;
    assign pc_wen = accept;
    // bubble holds off the cycle after a flush so the redirected pc_in can settle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            bubble <= 1'b0;
        end else begin
            bubble <= flush;
            state  <= halt ? HALTED : state == IDLE ? FETCH : state;
        end
    end
`ifdef FETCH_SKID_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_out  <= '0;
            npc_out    <= '0;
            valid_out  <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_npc   <= '0;
        end else if (halt || flush) begin
            valid_out  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                instr_out  <= skid_instr;
                npc_out    <= skid_npc;
                valid_out  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                instr_out <= imemload;
                npc_out   <= pc_in + 32'd4;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end else if (accept) begin
            skid_instr <= imemload;
            skid_npc   <= pc_in + 32'd4;
            skid_valid <= 1'b1;
        end
    end
`else
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_out <= '0;
            npc_out   <= '0;
            valid_out <= 1'b0;
        end else if (halt || flush) begin
            valid_out <= 1'b0;
        end else if (accept) begin
            instr_out <= imemload;
            npc_out   <= pc_in + 32'd4;
            valid_out <= 1'b1;
        end else if (!stall) begin
            valid_out <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a queue-based model of the IF/ID slot.
module tb_fetch_stage;
`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic        CLK = 1'b0;
    logic        nRST, ihit, flush, stall, halt;
    logic [31:0] pc_in, imemload;
    logic        pc_wen, imemREN, valid_out;
    logic [31:0] imemaddr, instr_out, npc_out;
    int checks = 0;
    int errors = 0;
    int m_phase = 0;
    bit m_bubble = 0;
    logic [63:0] q[$];

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .pc_wen(pc_wen), .imemREN(imemREN),
        .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload), .flush(flush),
        .stall(stall), .halt(halt), .instr_out(instr_out), .npc_out(npc_out),
        .valid_out(valid_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit rn, input logic [31:0] pc, input bit hit,
                         input logic [31:0] ld, input bit fl, input bit st, input bit hl);
        bit e_ren, e_wen;
        logic [63:0] head;
        nRST = rn; pc_in = pc; ihit = hit; imemload = ld; flush = fl; stall = st; halt = hl;
        #2;
        if (!rn) begin
            m_phase = 0;
            m_bubble = 0;
            q.delete();
        end
        e_ren = rn && m_phase == 1 && !m_bubble && !fl &&
                (CAP == 2 ? q.size() < 2 : (q.size() == 0 || !st));
        e_wen = e_ren && hit;
        chk("imemREN", {31'd0, imemREN}, {31'd0, e_ren});
        chk("pc_wen", {31'd0, pc_wen}, {31'd0, e_wen});
        chk("imemaddr", imemaddr, pc);
        chk("valid_out", {31'd0, valid_out}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            head = q[0];
            chk("instr_out", instr_out, head[63:32]);
            chk("npc_out", npc_out, head[31:0]);
        end
        if (!rn) begin
            chk("rst_instr", instr_out, 32'd0);
            chk("rst_npc", npc_out, 32'd0);
        end else begin
            if (hl || fl) q.delete();
            else begin
                if (!st && q.size() > 0) void'(q.pop_front());
                if (e_wen) q.push_back({ld, pc + 32'd4});
            end
            m_bubble = fl;
            m_phase = hl ? 2 : (m_phase == 0 ? 1 : m_phase);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 0; pc_in = 0; ihit = 0; imemload = 0; flush = 0; stall = 0; halt = 0;
        #1;
        cycle(0, 0, 1, 32'h8C010004, 0, 0, 0);
        cycle(0, 0, 1, 32'h8C010004, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h0, 1, 32'h8C010004, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h10, 1, 32'h11111111, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h10, 0, 32'h22222222, 0, i > 1, 0);
        cycle(1, 32'hFFFFFFFC, 1, 32'h33333333, 0, 0, 0);
        cycle(1, 32'h20, 0, 32'h0, 0, 0, 0);
        chk("wrap_npc", npc_out, 32'h00000000);
        cycle(1, 32'h24, 1, 32'h44444444, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 32'h80, 1, 32'h55555555, 0, 0, 0);
        cycle(1, 32'h84, 1, 32'h66666666, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 32'h88, 1, 32'h77777777, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 79) != 0,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC),
                  $urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
